// File: rtl/fdiv_seq_s.sv
// Sequential IEEE-754 binary32 divider using restoring radix-2 iteration and all five rounding modes.
// Latency: 28 cycles from the sampling edge for finite operands, 1 cycle for special operands.
// Backpressure: none. start_i is ignored while busy_o=1, and a new op can start in the cycle that done_o is high.
// Ports: clk/rstLow clock and async reset; rs1_i/rs2_i/frm_i operands and rounding mode;
//        start_i request; c_o/fflags_o registered result {NV,DZ,OF,UF,NX}; busy_o, done_o status.
module fdiv_seq_s (
    input  logic        clk,
    input  logic        rstLow,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [2:0]  frm_i,
    input  logic        start_i,
    output logic [31:0] c_o,
    output logic [4:0]  fflags_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, NORM, ITER, ROUND} state_t;

    state_t state, state_nxt;

    logic [31:0]        a_q, b_q;
    logic [2:0]         frm_q;
    logic [25:0]        rem_q;
    logic [23:0]        div_q;
    logic [25:0]        quo_q;
    logic signed [11:0] exp_q;
    logic [4:0]         cnt_q;

    // FSM control strobes
    logic load_op, ld_spec, ld_norm, iter_en, fin;

    // ---------------------------------------------------------------
    // Operand classification and special-case result (NORM)
    // ---------------------------------------------------------------
    logic        sgn;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;

    assign sgn = a_q[31] ^ b_q[31];
    assign ea  = a_q[30:23];
    assign eb  = b_q[30:23];
    assign fa  = a_q[22:0];
    assign fb  = b_q[22:0];

    always_comb begin
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'd0) && (fa == 23'd0);
        b_zero = (eb == 8'd0) && (fb == 23'd0);

        spec_hit   = 1'b1;
        spec_res   = 32'h7FC0_0000;
        spec_flags = 5'b10000;
        if (a_nan || b_nan) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 5'b10000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 5'b10000;
        end else if (frm_q > 3'd4) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 5'b10000;
        end else if (b_zero && !a_inf) begin
            spec_res   = {sgn, 31'h7F80_0000};
            spec_flags = 5'b01000;
        end else if (a_inf) begin
            spec_res   = {sgn, 31'h7F80_0000};
            spec_flags = 5'b00000;
        end else if (a_zero || b_inf) begin
            spec_res   = {sgn, 31'h0};
            spec_flags = 5'b00000;
        end else begin
            spec_hit   = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Significand normalization and exponent difference (NORM)
    // ---------------------------------------------------------------
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] lz;
        logic       found;
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      lz    = lz + 5'd1;
            end
        end
        return lz;
    endfunction

    logic [23:0]        ma_raw, mb_raw, ma_n, mb_n;
    logic [4:0]         lza, lzb;
    logic [7:0]         ea_adj, eb_adj;
    logic signed [11:0] ea_x, eb_x, exp_diff;

    always_comb begin
        ma_raw   = {(ea != 8'd0), fa};
        mb_raw   = {(eb != 8'd0), fb};
        lza      = lzc24(ma_raw);
        lzb      = lzc24(mb_raw);
        ma_n     = ma_raw << lza;
        mb_n     = mb_raw << lzb;
        // Subnormals share exponent 1 with the smallest normal; the bias cancels in the difference.
        ea_adj   = (ea == 8'd0) ? 8'd1 : ea;
        eb_adj   = (eb == 8'd0) ? 8'd1 : eb;
        ea_x     = $signed({4'b0, ea_adj}) - $signed({7'b0, lza});
        eb_x     = $signed({4'b0, eb_adj}) - $signed({7'b0, lzb});
        exp_diff = ea_x - eb_x;
    end

    // ---------------------------------------------------------------
    // One restoring quotient bit per cycle (ITER)
    // ---------------------------------------------------------------
    logic        q_bit;
    logic [25:0] rem_nxt;

    always_comb begin
        q_bit   = (rem_q >= {2'b00, div_q});
        rem_nxt = (q_bit ? (rem_q - {2'b00, div_q}) : rem_q) << 1;
    end

    // ---------------------------------------------------------------
    // Normalize, denormalize, round, pack (ROUND)
    // ---------------------------------------------------------------
    logic [23:0]        m, m2;
    logic               g, s, g2, s2, inc, denorm, ovf, nx;
    logic signed [11:0] be, sh_full;
    logic [4:0]         sh;
    logic [50:0]        ext;
    logic [7:0]         exp_base;
    logic [30:0]        packed_v, rounded;
    logic [31:0]        rnd_res, ovf_res;
    logic [4:0]         rnd_flags;

    always_comb begin
        // Quotient lies in (0.5, 2): shift once when the integer bit is clear.
        if (quo_q[25]) begin
            m  = quo_q[25:2];
            g  = quo_q[1];
            s  = quo_q[0] | (|rem_q);
            be = exp_q + 12'sd127;
        end else begin
            m  = quo_q[24:1];
            g  = quo_q[0];
            s  = |rem_q;
            be = exp_q + 12'sd126;
        end

        // Tiny results shift right into the subnormal field; anything past 26 places is pure sticky.
        denorm  = (be < 12'sd1);
        sh_full = 12'sd1 - be;
        sh      = 5'd0;
        if (denorm) sh = (sh_full > 12'sd26) ? 5'd26 : sh_full[4:0];
        ext     = {m, g, 26'b0} >> sh;
        m2      = ext[50:27];
        g2      = ext[26];
        s2      = s | (|ext[25:0]);

        case (frm_q)
            3'd0:    inc = g2 & (s2 | m2[0]);
            3'd2:    inc = sgn & (g2 | s2);
            3'd3:    inc = ~sgn & (g2 | s2);
            3'd4:    inc = g2;
            default: inc = 1'b0;
        endcase

        // The hidden bit adds one back into the exponent field; a rounding carry out of
        // the mantissa renormalizes by propagating into the exponent the same way.
        exp_base = denorm ? 8'd0 : (be[7:0] - 8'd1);
        packed_v = {exp_base, 23'b0} + {7'b0, m2};
        rounded  = packed_v + {30'b0, inc};

        ovf = (be > 12'sd254) || (rounded[30:23] == 8'hFF);
        nx  = g2 | s2 | ovf;

        case (frm_q)
            3'd1:    ovf_res = {sgn, 31'h7F7F_FFFF};
            3'd2:    ovf_res = sgn ? 32'hFF80_0000 : 32'h7F7F_FFFF;
            3'd3:    ovf_res = sgn ? 32'hFF7F_FFFF : 32'h7F80_0000;
            default: ovf_res = {sgn, 31'h7F80_0000};
        endcase

        if (ovf) begin
            rnd_res   = ovf_res;
            rnd_flags = 5'b00101;
        end else begin
            rnd_res   = {sgn, rounded};
            rnd_flags = {3'b000, (rounded[30:23] == 8'd0) && nx, nx};
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_op   = 1'b0;
        ld_spec   = 1'b0;
        ld_norm   = 1'b0;
        iter_en   = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    load_op   = 1'b1;
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (spec_hit) begin
                    ld_spec   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ld_norm   = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                iter_en = 1'b1;
                if (cnt_q == 5'd25) state_nxt = ROUND;
            end
            ROUND: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            frm_q    <= 3'd0;
            rem_q    <= 26'd0;
            div_q    <= 24'd0;
            quo_q    <= 26'd0;
            exp_q    <= 12'sd0;
            cnt_q    <= 5'd0;
            c_o      <= 32'd0;
            fflags_o <= 5'd0;
            done_o   <= 1'b0;
        end else begin
            done_o <= ld_spec | fin;
            if (load_op) begin
                a_q   <= rs1_i;
                b_q   <= rs2_i;
                frm_q <= frm_i;
            end
            if (ld_norm) begin
                rem_q <= {2'b00, ma_n};
                div_q <= mb_n;
                quo_q <= 26'd0;
                exp_q <= exp_diff;
                cnt_q <= 5'd0;
            end
            if (iter_en) begin
                rem_q <= rem_nxt;
                quo_q <= {quo_q[24:0], q_bit};
                cnt_q <= (cnt_q == 5'd25) ? 5'd0 : cnt_q + 5'd1;
            end
            if (ld_spec) begin
                c_o      <= spec_res;
                fflags_o <= spec_flags;
            end
            if (fin) begin
                c_o      <= rnd_res;
                fflags_o <= rnd_flags;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_seq_s.sv
// Self-checking bench for fdiv_seq_s: exact rational reference model, per-cycle output compare.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fdiv_seq_s;

    logic        clk = 1'b0;
    logic        rstLow = 1'b1;
    logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
    logic [2:0]  frm = 3'd0;
    logic        start = 1'b0;
    logic [31:0] c_o;
    logic [4:0]  fflags_o;
    logic        busy_o, done_o;

    fdiv_seq_s dut (
        .clk      (clk),
        .rstLow   (rstLow),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .frm_i    (frm),
        .start_i  (start),
        .c_o      (c_o),
        .fflags_o (fflags_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          start_cyc;
        int          due;
    } exp_t;
    exp_t expq[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact quotient of the integer significands, rounded to binary32 from first principles.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                                  output logic [31:0] res, output logic [4:0] fl, output bit sp);
        logic s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, g, st, inc, nx;
        logic [23:0] ma, mb;
        logic [127:0] num, q, r, mask;
        logic [24:0] keep;
        int xa, xb, base, p, e, u, k, bexp;
        s = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        nan_a = (ea == 8'hFF) && (fa != 0); nan_b = (eb == 8'hFF) && (fb != 0);
        inf_a = (ea == 8'hFF) && (fa == 0); inf_b = (eb == 8'hFF) && (fb == 0);
        zero_a = (ea == 0) && (fa == 0);    zero_b = (eb == 0) && (fb == 0);
        sp = 1'b1; fl = 5'b00000; res = 32'h7FC00000;
        if (nan_a || nan_b)                          begin res = 32'h7FC00000; fl = 5'b10000; end
        else if ((zero_a && zero_b) || (inf_a && inf_b)) begin res = 32'h7FC00000; fl = 5'b10000; end
        else if (rm > 3'd4)                          begin res = 32'h7FC00000; fl = 5'b10000; end
        else if (zero_b && !inf_a)                   begin res = {s, 31'h7F800000}; fl = 5'b01000; end
        else if (inf_a)                              res = {s, 31'h7F800000};
        else if (zero_a || inf_b)                    res = {s, 31'h0};
        else begin
            sp = 1'b0;
            // value = m * 2^x with integer significand m
            ma = {(ea != 0), fa}; mb = {(eb != 0), fb};
            xa = ((ea == 0) ? 1 : int'(ea)) - 150;
            xb = ((eb == 0) ? 1 : int'(eb)) - 150;
            num = {104'b0, ma} << 64;
            q = num / {104'b0, mb};
            r = num % {104'b0, mb};
            base = xa - xb - 64;
            p = 0;
            for (int i = 0; i < 128; i++) if (q[i]) p = i;
            e = p + base;
            u = (e - 23 > -149) ? e - 23 : -149;
            k = u - base;
            if (k >= 120) begin
                keep = 25'd0; g = 1'b0; st = 1'b1;
            end else begin
                keep = 25'(q >> k);
                g = q[k-1];
                mask = (128'd1 << (k - 1)) - 128'd1;
                st = ((q & mask) != 0) || (r != 0);
            end
            case (rm)
                3'd0: inc = g && (st || keep[0]);
                3'd2: inc = s && (g || st);
                3'd3: inc = !s && (g || st);
                3'd4: inc = g;
                default: inc = 1'b0;
            endcase
            keep = keep + {24'd0, inc};
            if (keep[24]) begin keep = keep >> 1; u++; end
            bexp = keep[23] ? u + 150 : 0;
            nx = g || st;
            if (bexp >= 255) begin
                fl = 5'b00101;
                case (rm)
                    3'd1: res = {s, 31'h7F7FFFFF};
                    3'd2: res = s ? 32'hFF800000 : 32'h7F7FFFFF;
                    3'd3: res = s ? 32'hFF7FFFFF : 32'h7F800000;
                    default: res = {s, 31'h7F800000};
                endcase
            end else begin
                res = {s, 8'(bexp), keep[22:0]};
                fl = {3'b000, (bexp == 0) && nx, nx};
            end
        end
    endfunction

    // Per-cycle compare against the expected-transaction queue.
    logic [31:0] last_c = 32'd0;
    logic [4:0]  last_f = 5'd0;
    bit last_done = 1'b0;
    bit eb_x, ed_x;

    always @(negedge clk) begin
        if (!rstLow) begin
            check32("reset_c_o", c_o, 32'h0);
            check32("reset_fflags", 32'(fflags_o), 32'h0);
            check32("reset_busy", 32'(busy_o), 32'h0);
            check32("reset_done", 32'(done_o), 32'h0);
            last_c = 32'd0; last_f = 5'd0; last_done = 1'b0;
        end else begin
            eb_x = 1'b0; ed_x = 1'b0;
            if (expq.size() > 0) begin
                eb_x = (cyc > expq[0].start_cyc) && (cyc < expq[0].due);
                ed_x = (cyc == expq[0].due);
            end
            check32("busy", 32'(busy_o), 32'(eb_x));
            check32("done", 32'(done_o), 32'(ed_x));
            if (ed_x) begin
                check32("result", c_o, expq[0].res);
                check32("fflags", 32'(fflags_o), 32'(expq[0].fl));
                last_c = expq[0].res; last_f = expq[0].fl;
            end else if (!done_o) begin
                check32("hold_c_o", c_o, last_c);
                check32("hold_fflags", 32'(fflags_o), 32'(last_f));
            end
            if (done_o && last_done) begin
                checks++; errors++;
                $display("FAIL done_twice: done_o high on two consecutive cycles (cycle %0d)", cyc);
            end
            last_done = done_o;
            if (expq.size() > 0 && cyc >= expq[0].due) void'(expq.pop_front());
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic [31:0] mr; logic [4:0] mf; bit sp;
        @(negedge clk); #1;
        model(a, b, rm, mr, mf, sp);
        rs1 = a; rs2 = b; frm = rm; start = 1'b1;
        expq.push_back('{res: mr, fl: mf, start_cyc: cyc, due: cyc + (sp ? 2 : 29)});
        @(negedge clk); #1;
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; frm = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
        if (expq.size() != 0) begin
            checks++; errors++;
            $display("FAIL wait_idle: queue still holds %0d ops after %0d cycles", expq.size(), n);
            expq.delete();
        end
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        while (!done_o && n < 100) begin @(negedge clk); #1; n++; end
        if (!done_o) begin
            checks++; errors++;
            $display("FAIL wait_done: no done_o within %0d cycles", n);
        end
        at = cyc;
    endtask

    task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                           input logic [31:0] er, input logic [4:0] ef);
        logic [31:0] mr; logic [4:0] mf; bit sp;
        model(a, b, rm, mr, mf, sp);
        check32("model_res", mr, er);
        check32("model_flags", 32'(mf), 32'(ef));
        issue(a, b, rm);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2;
        #1 rstLow = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rstLow = 1'b1;

        run_vec(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000);
        run_vec(32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001);
        run_vec(32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001);
        run_vec(32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00001);
        run_vec(32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00001);
        run_vec(32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 5'b00001);
        run_vec(32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00001);
        run_vec(32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 5'b00001);
        run_vec(32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b01000);
        run_vec(32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000);
        run_vec(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000);
        run_vec(32'h3F800000, 32'h3F800000, 3'd5, 32'h7FC00000, 5'b10000);
        run_vec(32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 5'b00000);
        run_vec(32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 5'b00000);
        run_vec(32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b00000);
        run_vec(32'h00000000, 32'h7F800000, 3'd0, 32'h00000000, 5'b00000);
        run_vec(32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b10000);
        run_vec(32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'b00101);
        run_vec(32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'b00101);
        run_vec(32'hFF7FFFFF, 32'h3F000000, 3'd2, 32'hFF800000, 5'b00101);
        run_vec(32'hFF7FFFFF, 32'h3F000000, 3'd3, 32'hFF7FFFFF, 5'b00101);
        run_vec(32'h00800000, 32'h40000000, 3'd0, 32'h00400000, 5'b00000);
        run_vec(32'h00800001, 32'h40000000, 3'd0, 32'h00400000, 5'b00011);
        run_vec(32'h3F800000, 32'h00400000, 3'd0, 32'h7F000000, 5'b00000);
        run_vec(32'h00000001, 32'h4B000000, 3'd0, 32'h00000000, 5'b00011);
        run_vec(32'h00000001, 32'h4B000000, 3'd3, 32'h00000001, 5'b00011);

        // start held high while busy must not queue a second op
        issue(32'h40C00000, 32'h40000000, 3'd0);
        repeat (2) @(negedge clk);
        #1;
        rs1 = 32'h3F800000; rs2 = 32'h00000000; frm = 3'd0; start = 1'b1;
        repeat (24) @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // back-to-back: second start in the IDLE cycle carrying done_o
        issue(32'h3F800000, 32'h40400000, 3'd0);
        wait_done(d1);
        begin
            logic [31:0] mr; logic [4:0] mf; bit sp;
            model(32'h40C00000, 32'h40000000, 3'd0, mr, mf, sp);
            rs1 = 32'h40C00000; rs2 = 32'h40000000; frm = 3'd0; start = 1'b1;
            expq.push_back('{res: mr, fl: mf, start_cyc: cyc, due: cyc + 29});
        end
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(d2);
        check32("b2b_gap", 32'(d2 - d1), 32'd29);
        wait_idle();

        // reset mid-operation: outputs clear at once, no done_o, next op normal
        issue(32'h7F7FFFFF, 32'h3F000000, 3'd1);
        repeat (9) @(negedge clk);
        #1;
        rstLow = 1'b0;
        expq.delete();
        #1;
        check32("midrst_c_o", c_o, 32'h0);
        check32("midrst_fflags", 32'(fflags_o), 32'h0);
        check32("midrst_busy", 32'(busy_o), 32'h0);
        check32("midrst_done", 32'(done_o), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        rstLow = 1'b1;
        repeat (35) @(negedge clk);
        run_vec(32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
